// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - core/ext arbiter for the single-port data RAM
// Core wins by default; ext gets a guaranteed slot after MAX_WAIT and optional locked bursts.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 18,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIM   = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {S_CORE, S_EXT, S_COOL} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_EXT} owner_t;

  state_t              state_q, state_d;
  owner_t              rd_owner_q, rd_owner_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                core_gnt;
  logic                ext_gnt_c;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    core_gnt    = 1'b0;
    ext_gnt_c   = 1'b0;
    // Grants are forced low during reset so every RAM-facing output is quiet immediately.
    if (!rst) begin
      case (state_q)
        S_CORE: begin
          if (ext_req && (!core_req || wait_cnt_q == WAIT_LIM)) begin
            ext_gnt_c = 1'b1;
          end else begin
            core_gnt = core_req;
          end
          if (ext_gnt_c && ext_lock) begin
            state_d     = S_EXT;
            burst_cnt_d = BURST_W'(1);
          end
        end
        S_EXT: begin
          ext_gnt_c = ext_req;
          if (!ext_req || !ext_lock || burst_cnt_q == BURST_LAST) begin
            state_d     = S_COOL;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
          end
        end
        S_COOL: begin
          core_gnt = core_req;
          state_d  = S_CORE;
        end
        default: state_d = S_CORE;
      endcase
    end

    wait_cnt_d = wait_cnt_q;
    if (!ext_req || ext_gnt_c) begin
      wait_cnt_d = '0;
    end else if (state_q != S_COOL && wait_cnt_q != WAIT_LIM) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    rd_owner_d = RD_NONE;
    if (core_gnt && !core_we) begin
      rd_owner_d = RD_CORE;
    end else if (ext_gnt_c && !ext_we) begin
      rd_owner_d = RD_EXT;
    end

    // Return data passes straight through in the return cycle, then is held.
    core_rdata_d = (rd_owner_q == RD_CORE) ? mem_rdata : core_rdata_q;
    ext_rdata_d  = (rd_owner_q == RD_EXT)  ? mem_rdata : ext_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CORE;
      rd_owner_q   <= RD_NONE;
      wait_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_owner_q   <= rd_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign core_stall = core_req && !core_gnt && !rst;
  assign ext_gnt    = ext_gnt_c;
  assign ext_rvalid = (rd_owner_q == RD_EXT);
  assign core_rdata = core_rdata_d;
  assign ext_rdata  = ext_rdata_d;
  assign mem_en     = core_gnt || ext_gnt_c;
  assign mem_we     = core_gnt ? core_we    : (ext_gnt_c ? ext_we    : 1'b0);
  assign mem_addr   = core_gnt ? core_addr  : (ext_gnt_c ? ext_addr  : '0);
  assign mem_wdata  = core_gnt ? core_wdata : (ext_gnt_c ? ext_wdata : '0);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - vector-table bench for dmem_port_arbiter with a 1-cycle RAM model
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_stall;
  logic [9:0]  core_addr;
  logic [17:0] core_wdata, core_rdata;
  logic        ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
  logic [9:0]  ext_addr;
  logic [17:0] ext_wdata, ext_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [17:0] mem_wdata, mem_rdata;

  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [17:0] ld_data;
  logic [17:0] ram [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        creq, cwe;
    logic [9:0]  caddr;
    logic [17:0] cwd;
    logic        ereq, ewe, elock;
    logic [9:0]  eaddr;
    logic [17:0] ewd;
    logic        x_stall, x_gnt, x_en, x_we;
    logic [9:0]  x_addr;
    logic [17:0] x_wdata, x_crd;
    logic        x_rv;
    logic [17:0] x_erd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic creq, cwe, input logic [9:0] caddr, input logic [17:0] cwd,
    input logic ereq, ewe, elock, input logic [9:0] eaddr, input logic [17:0] ewd,
    input logic x_stall, x_gnt, x_en, x_we, input logic [9:0] x_addr,
    input logic [17:0] x_wdata, x_crd, input logic x_rv, input logic [17:0] x_erd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.ereq = ereq; v.ewe = ewe; v.elock = elock; v.eaddr = eaddr; v.ewd = ewd;
    v.x_stall = x_stall; v.x_gnt = x_gnt; v.x_en = x_en; v.x_we = x_we;
    v.x_addr = x_addr; v.x_wdata = x_wdata; v.x_crd = x_crd; v.x_rv = x_rv; v.x_erd = x_erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic creq, cwe, input logic [9:0] caddr, input logic [17:0] cwd,
                       input logic ereq, ewe, elock, input logic [9:0] eaddr,
                       input logic [17:0] ewd);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    ext_req = ereq; ext_we = ewe; ext_lock = elock; ext_addr = eaddr; ext_wdata = ewd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [17:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    next_cycle();
    ld_en = 1'b0;
  endtask

  initial begin
    int n_ext;
    rst = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    load(10'h010, 18'h2ABCD);
    load(10'h005, 18'h15555);
    load(10'h030, 18'h00000);
    load(10'h020, 18'h00000);
    load(10'h040, 18'h00000);
    load(10'h060, 18'h0F0F0);
    #3;
    chk("reset_mem_en", mem_en, 0);
    chk("reset_ext_gnt", ext_gnt, 0);
    chk("reset_rvalid", ext_rvalid, 0);
    chk("reset_core_rdata", core_rdata, 0);
    chk("reset_ext_rdata", ext_rdata, 0);
    next_cycle();
    rst = 1'b0;

    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,10'h010,0, 0,0,0,0,0,         0,0,1,0,10'h010,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 18'h2ABCD,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 18'h2ABCD,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,10'h005,0,         0,1,1,0,10'h005,0, 18'h2ABCD,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 18'h2ABCD,1,18'h15555));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 18'h2ABCD,0,18'h15555));
    vecs.push_back(mk(1,0,10'h030,0, 1,1,0,10'h020,18'h00123, 0,0,1,0,10'h030,0, 18'h2ABCD,0,18'h15555));
    vecs.push_back(mk(1,0,10'h030,0, 1,1,0,10'h020,18'h00123, 0,0,1,0,10'h030,0, 0,0,18'h15555));
    vecs.push_back(mk(1,0,10'h030,0, 1,1,0,10'h020,18'h00123, 0,0,1,0,10'h030,0, 0,0,18'h15555));
    vecs.push_back(mk(1,0,10'h030,0, 1,1,0,10'h020,18'h00123, 0,0,1,0,10'h030,0, 0,0,18'h15555));
    vecs.push_back(mk(1,0,10'h030,0, 1,1,0,10'h020,18'h00123, 1,1,1,1,10'h020,18'h00123, 0,0,18'h15555));
    vecs.push_back(mk(1,0,10'h030,0, 0,0,0,0,0,         0,0,1,0,10'h030,0, 0,0,18'h15555));
    vecs.push_back(mk(1,0,10'h020,0, 0,0,0,0,0,         0,0,1,0,10'h020,0, 0,0,18'h15555));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 18'h00123,0,18'h15555));
    vecs.push_back(mk(1,1,10'h040,18'h3FFFF, 1,0,0,10'h040,0, 0,0,1,1,10'h040,18'h3FFFF, 18'h00123,0,18'h15555));
    vecs.push_back(mk(0,0,0,0, 1,0,0,10'h040,0,         0,1,1,0,10'h040,0, 18'h00123,0,18'h15555));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 18'h00123,1,18'h3FFFF));
    vecs.push_back(mk(0,0,0,0, 1,1,1,10'h050,18'h00001, 0,1,1,1,10'h050,18'h00001, 18'h00123,0,18'h3FFFF));
    vecs.push_back(mk(1,0,10'h010,0, 0,0,0,0,0,         1,0,0,0,0,0, 18'h00123,0,18'h3FFFF));
    vecs.push_back(mk(1,0,10'h010,0, 1,1,1,10'h050,18'h00001, 0,0,1,0,10'h010,0, 18'h00123,0,18'h3FFFF));
    vecs.push_back(mk(0,0,0,0, 1,1,1,10'h050,18'h00001, 0,1,1,1,10'h050,18'h00001, 18'h2ABCD,0,18'h3FFFF));
    vecs.push_back(mk(0,0,0,0, 1,1,0,10'h051,18'h00002, 0,1,1,1,10'h051,18'h00002, 18'h2ABCD,0,18'h3FFFF));
    vecs.push_back(mk(0,0,0,0, 1,0,0,10'h005,0,         0,0,0,0,0,0, 18'h2ABCD,0,18'h3FFFF));
    vecs.push_back(mk(0,0,0,0, 1,0,0,10'h005,0,         0,1,1,0,10'h005,0, 18'h2ABCD,0,18'h3FFFF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,               0,0,0,0,0,0, 18'h2ABCD,1,18'h15555));

    foreach (vecs[i]) begin
      next_cycle();
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].ereq, vecs[i].ewe, vecs[i].elock, vecs[i].eaddr, vecs[i].ewd);
      #3;
      chk($sformatf("v%0d_core_stall", i), core_stall, vecs[i].x_stall);
      chk($sformatf("v%0d_ext_gnt", i),    ext_gnt,    vecs[i].x_gnt);
      chk($sformatf("v%0d_mem_en", i),     mem_en,     vecs[i].x_en);
      chk($sformatf("v%0d_mem_we", i),     mem_we,     vecs[i].x_we);
      chk($sformatf("v%0d_mem_addr", i),   mem_addr,   vecs[i].x_addr);
      chk($sformatf("v%0d_mem_wdata", i),  mem_wdata,  vecs[i].x_wdata);
      chk($sformatf("v%0d_core_rdata", i), core_rdata, vecs[i].x_crd);
      chk($sformatf("v%0d_ext_rvalid", i), ext_rvalid, vecs[i].x_rv);
      chk($sformatf("v%0d_ext_rdata", i),  ext_rdata,  vecs[i].x_erd);
    end

    // Locked burst against a busy core: 4 waits, 8 ext grants, 1 cool-down slot, 4 waits, burst again.
    n_ext = 0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      drive(1, 0, 10'h010, 0, 1, 0, 1, 10'h060, 0);
      #3;
      begin
        logic exp_gnt;
        exp_gnt = ((c >= 4 && c <= 11) || c >= 17);
        chk($sformatf("burst_c%0d_ext_gnt", c), ext_gnt, exp_gnt);
        chk($sformatf("burst_c%0d_core_stall", c), core_stall, exp_gnt);
        if (c >= 4 && c <= 11 && ext_gnt) n_ext++;
      end
    end
    chk("burst_grant_count", n_ext, 8);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Reset right after an ext read grant drops the pending return.
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 10'h005, 0);
    #3;
    chk("rst_pre_ext_gnt", ext_gnt, 1);
    next_cycle();
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_ext_rvalid", ext_rvalid, 0);
    chk("rst_ext_rdata", ext_rdata, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_mem_en", mem_en, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(1, 0, 10'h010, 0, 1, 0, 0, 10'h005, 0);
    #3;
    chk("post_rst_core_first", mem_addr, 10'h010);
    chk("post_rst_ext_gnt", ext_gnt, 0);
    chk("post_rst_rvalid", ext_rvalid, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("post_rst_core_rdata", core_rdata, 18'h2ABCD);
    chk("post_rst_rvalid2", ext_rvalid, 0);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
